turbosound_stereo_mixer: RTL and testbench
==========================================

// Module: turbosound_stereo_mixer
// PURPOSE
//  Stage directly downstream of the dual-AY TurboSound block. Consumes both chips' per-channel
//  8-bit outputs plus the ULA EAR/MIC beeper bits. Mixes them into left/right PCM according to
//  the selected stereo mode, applies a volume shift and saturation, and drives two first-order
//  sigma-delta 1-bit DAC pins. Sits between the sound chips and the board audio pins.
// PARAMETERS
//  W         12     PCM width of pcm_l/pcm_r and sigma-delta accumulator base width
//  BEEP_EAR  400    PCM weight added to both sides when ear=1
//  BEEP_MIC  100    PCM weight added to both sides when mic=1
// PORTS
//  clk              in   1   system clock
//  reset_n          in   1   synchronous, active-low reset
//  clk35en          in   1   3.5 MHz clock-enable strobe, one clk wide; paces the mix pipeline
//  ay1_abc          in   24  AY1 channels: A=[23:16], B=[15:8], C=[7:0], unsigned
//  ay2_abc          in   24  AY2 channels, same packing
//  disable_ay       in   1   1: both AY contributions forced to 0
//  disable_turboay  in   1   1: AY2 contribution forced to 0
//  ear              in   1   beeper EAR bit
//  mic              in   1   beeper MIC bit
//  stereo_mode      in   2   00 mono, 01 ABC, 10 ACB, 11 split (AY1 left, AY2 right)
//  vol_shift        in   2   attenuation: final PCM >> vol_shift
//  pcm_l            out  W   left PCM, unsigned
//  pcm_r            out  W   right PCM, unsigned
//  pcm_strobe       out  1   1-clk pulse on each clk when pcm_l/pcm_r are updated
//  dac_l            out  1   left sigma-delta bit
//  dac_r            out  1   right sigma-delta bit
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): all pipeline regs, pcm_l, pcm_r, pcm_strobe, dac_l, dac_r
//    and both accumulators go to 0. Reset overrides clk35en. Reset mid-pipeline discards data.
//  - Stage 1, on clk35en: capture ay1_abc, ay2_abc (masked per disable_* at capture),
//    ear, mic, stereo_mode, vol_shift.
//  - Stage 2, on clk35en: compute per-AY sides from captured values, both sides in 13 bits,
//    sum both AYs, add beeper:
//      mono:  L = R = A+B+C          ABC: L = 2A+B, R = 2C+B
//      ACB:   L = 2A+C,  R = 2B+C    split: L = 2(A1+B1+C1), R = 2(A2+B2+C2)
//    Split mode uses no cross-AY sum. Beeper = (ear?BEEP_EAR:0)+(mic?BEEP_MIC:0), added to both
//    sides in every mode. Saturate to 2^W-1, then shift right by vol_shift. Register to
//    pcm_l/pcm_r; assert pcm_strobe that clk.
//  - Latency: an input change present at clk35en strobe N appears on pcm_* after strobe N+1.
//    pcm_* are stable between strobes.
//  - Max unsaturated AY sum = 1530 (4*255 + 2*255); saturation only matters for large BEEP_*.
//  - Sigma-delta, every clk (not gated by clk35en):
//      acc <= {1'b0, acc[W-1:0]} + pcm;   dac = acc[W]  (W+1-bit accumulator).
//    Over 2^W clks with constant pcm = P, dac is 1 exactly P times.
//  - disable_* changes take effect at the next stage-1 capture; AY2 stale data is never mixed
//    while disable_turboay=1. stereo_mode changes mid-stream: no glitch beyond one strobe period.
// STRUCTURE
//  - Shared package/header: stereo-mode constants MODE_MONO/ABC/ACB/SPLIT, default W.
//  - One sub-module: sigma_delta_dac #(W) (clk, reset_n, pcm, dac), instantiated for L and R.
//  - Mixer pipeline and saturation live in the top module.
// TESTING
//  1. Reset: hold reset_n=0 with inputs active -> all outputs 0; pcm_* = 0 on 1st strobe after
//     release; correct values after 2nd strobe.
//  2. ABC: ay1 A=255, B=0, C=0, ay2=0, vol_shift=0 -> pcm_l=510, pcm_r=0; ACB with B=100 ->
//     pcm_l=0, pcm_r=200.
//  3. Split: all ay1 channels=255, all ay2 channels=10 -> pcm_l=1530, pcm_r=60; then
//     disable_turboay=1 -> pcm_r=0 two strobes later.
//  4. Saturation/volume: BEEP_EAR=4000, ear=1, mono with all channels=255 -> pcm_l=pcm_r=4095;
//     vol_shift=2 -> 1023.
//  5. DAC: force pcm_l=2048 steady -> dac_l toggles every clk; pcm_l=1 -> exactly one 1 per
//     4096 clks; pcm_l=0 -> dac_l stays 0.
//  6. Strobe: clk35en every 8 clks -> pcm_strobe is one clk wide, 8 clks apart; no clk35en ->
//     pcm_* frozen.

Source files
------------

// File: rtl/turbosound_stereo_mixer_pkg.sv
// Shared types and constants for the TurboSound stereo mixer: stereo-mode encoding,
// AY channel packing and the per-chip side-mix helper.
package turbosound_stereo_mixer_pkg;

    localparam int DEFAULT_W = 12;
    localparam int SIDE_W    = 13;

    typedef enum logic [1:0] {
        MODE_MONO  = 2'b00,
        MODE_ABC   = 2'b01,
        MODE_ACB   = 2'b10,
        MODE_SPLIT = 2'b11
    } stereo_mode_e;

    // Matches the bus packing: A in the top byte, C in the bottom byte.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } ay_abc_t;

    typedef struct packed {
        logic [SIDE_W-1:0] l;
        logic [SIDE_W-1:0] r;
    } side_pair_t;

    // Left/right contribution of one chip. In split mode both sides carry the doubled
    // chip total; the caller picks AY1's left and AY2's right.
    function automatic side_pair_t ay_sides(input ay_abc_t ay, input stereo_mode_e mode);
        logic [SIDE_W-1:0] a, b, c;
        side_pair_t        s;
        a = SIDE_W'(ay.a);
        b = SIDE_W'(ay.b);
        c = SIDE_W'(ay.c);
        case (mode)
            MODE_MONO: begin
                s.l = a + b + c;
                s.r = a + b + c;
            end
            MODE_ABC: begin
                s.l = (a << 1) + b;
                s.r = (c << 1) + b;
            end
            MODE_ACB: begin
                s.l = (a << 1) + c;
                s.r = (b << 1) + c;
            end
            default: begin
                s.l = (a + b + c) << 1;
                s.r = (a + b + c) << 1;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/turbosound_stereo_mixer_if.sv
// Sound-side bus of the stereo mixer: chip/beeper inputs, mix controls and the PCM result.
interface turbosound_stereo_mixer_if
    import turbosound_stereo_mixer_pkg::*;
#(
    parameter int W = DEFAULT_W
) ();

    logic         clk35en;
    logic [23:0]  ay1_abc;
    logic [23:0]  ay2_abc;
    logic         disable_ay;
    logic         disable_turboay;
    logic         ear;
    logic         mic;
    logic [1:0]   stereo_mode;
    logic [1:0]   vol_shift;
    logic [W-1:0] pcm_l;
    logic [W-1:0] pcm_r;
    logic         pcm_strobe;

    modport master (
        output clk35en, ay1_abc, ay2_abc, disable_ay, disable_turboay,
               ear, mic, stereo_mode, vol_shift,
        input  pcm_l, pcm_r, pcm_strobe
    );

    modport slave (
        input  clk35en, ay1_abc, ay2_abc, disable_ay, disable_turboay,
               ear, mic, stereo_mode, vol_shift,
        output pcm_l, pcm_r, pcm_strobe
    );

endinterface

// File: rtl/turbosound_stereo_mixer_sigma_delta_dac.sv
// First-order sigma-delta 1-bit DAC: the carry out of a W-bit accumulator is the pin.
module sigma_delta_dac
    import turbosound_stereo_mixer_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] pcm,
    output logic         dac
);

    logic [W:0] acc;

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[W-1:0]} + {1'b0, pcm};
        end
    end

    // Over 2^W cycles at constant pcm the carry fires exactly pcm times.
    assign dac = acc[W];

endmodule

// File: rtl/turbosound_stereo_mixer.sv
// Dual-AY + beeper stereo mixer: two-stage clk35en pipeline with saturation and volume
// shift, feeding one sigma-delta DAC per side.
module turbosound_stereo_mixer
    import turbosound_stereo_mixer_pkg::*;
#(
    parameter int W        = DEFAULT_W,
    parameter int BEEP_EAR = 400,
    parameter int BEEP_MIC = 100
) (
    input  logic                      clk,
    input  logic                      reset_n,
    turbosound_stereo_mixer_if.slave  bus,
    output logic                      dac_l,
    output logic                      dac_r
);

    localparam logic [31:0] PCM_MAX  = 32'((1 << W) - 1);
    localparam logic [31:0] EAR_WGT  = 32'(BEEP_EAR);
    localparam logic [31:0] MIC_WGT  = 32'(BEEP_MIC);

    // Stage 1: captured inputs, with chip masking applied at capture so stale AY2 data
    // can never reach the mix while it is disabled.
    ay_abc_t      s1_ay1;
    ay_abc_t      s1_ay2;
    logic         s1_ear;
    logic         s1_mic;
    stereo_mode_e s1_mode;
    logic [1:0]   s1_vol;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_ay1  <= '0;
            s1_ay2  <= '0;
            s1_ear  <= 1'b0;
            s1_mic  <= 1'b0;
            s1_mode <= MODE_MONO;
            s1_vol  <= '0;
        end else if (bus.clk35en) begin
            s1_ay1  <= bus.disable_ay ? '0 : ay_abc_t'(bus.ay1_abc);
            s1_ay2  <= (bus.disable_ay || bus.disable_turboay) ? '0 : ay_abc_t'(bus.ay2_abc);
            s1_ear  <= bus.ear;
            s1_mic  <= bus.mic;
            s1_mode <= stereo_mode_e'(bus.stereo_mode);
            s1_vol  <= bus.vol_shift;
        end
    end

    // Stage 2 datapath: side mix, beeper, saturation, volume.
    side_pair_t   sides1;
    side_pair_t   sides2;
    logic [31:0]  mix_l;
    logic [31:0]  mix_r;
    logic [31:0]  beep;
    logic [31:0]  sum_l;
    logic [31:0]  sum_r;
    logic [W-1:0] sat_l;
    logic [W-1:0] sat_r;
    logic [W-1:0] next_l;
    logic [W-1:0] next_r;

    // NOTE: every signal driven here gets a default first so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        sides1 = ay_sides(s1_ay1, s1_mode);
        sides2 = ay_sides(s1_ay2, s1_mode);
        mix_l  = 32'(sides1.l) + 32'(sides2.l);
        mix_r  = 32'(sides1.r) + 32'(sides2.r);
        if (s1_mode == MODE_SPLIT) begin
            mix_l = 32'(sides1.l);
            mix_r = 32'(sides2.r);
        end

        beep = (s1_ear ? EAR_WGT : 32'd0) + (s1_mic ? MIC_WGT : 32'd0);
        sum_l = mix_l + beep;
        sum_r = mix_r + beep;

        sat_l = (sum_l > PCM_MAX) ? PCM_MAX[W-1:0] : sum_l[W-1:0];
        sat_r = (sum_r > PCM_MAX) ? PCM_MAX[W-1:0] : sum_r[W-1:0];

        next_l = sat_l >> s1_vol;
        next_r = sat_r >> s1_vol;
    end

    logic [W-1:0] pcm_l_q;
    logic [W-1:0] pcm_r_q;
    logic         pcm_strobe_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcm_l_q      <= '0;
            pcm_r_q      <= '0;
            pcm_strobe_q <= 1'b0;
        end else begin
            pcm_strobe_q <= bus.clk35en;
            if (bus.clk35en) begin
                pcm_l_q <= next_l;
                pcm_r_q <= next_r;
            end
        end
    end

    assign bus.pcm_l      = pcm_l_q;
    assign bus.pcm_r      = pcm_r_q;
    assign bus.pcm_strobe = pcm_strobe_q;

    // The DACs run every clk, not on the 3.5 MHz enable.
    sigma_delta_dac #(.W(W)) u_dac_l (
        .clk     (clk),
        .reset_n (reset_n),
        .pcm     (pcm_l_q),
        .dac     (dac_l)
    );

    sigma_delta_dac #(.W(W)) u_dac_r (
        .clk     (clk),
        .reset_n (reset_n),
        .pcm     (pcm_r_q),
        .dac     (dac_r)
    );

endmodule

// File: tb/tb_turbosound_stereo_mixer.sv
// Directed bench for turbosound_stereo_mixer: one instance with a large EAR weight for
// saturation, one with weights chosen to hit exact DAC codes 2048 / 1 / 0.
module tb_turbosound_stereo_mixer;
    import turbosound_stereo_mixer_pkg::*;

    localparam int W = 12;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic dac_l, dac_r, d_dac_l, d_dac_r;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    turbosound_stereo_mixer_if #(.W(W)) bus  ();
    turbosound_stereo_mixer_if #(.W(W)) dbus ();

    assign dbus.clk35en = bus.clk35en;

    turbosound_stereo_mixer #(.W(W), .BEEP_EAR(4000), .BEEP_MIC(100)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .dac_l   (dac_l),
        .dac_r   (dac_r)
    );

    turbosound_stereo_mixer #(.W(W), .BEEP_EAR(2048), .BEEP_MIC(1)) u_dac_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dbus),
        .dac_l   (d_dac_l),
        .dac_r   (d_dac_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk) bus.clk35en = 1'b1;
        @(negedge clk) bus.clk35en = 1'b0;
    endtask

    task automatic set_in(input logic [23:0] ay1, input logic [23:0] ay2, input logic [1:0] mode,
                          input logic [1:0] vol, input logic e, input logic m,
                          input logic dis_ay, input logic dis_t);
        bus.ay1_abc         = ay1;
        bus.ay2_abc         = ay2;
        bus.stereo_mode     = mode;
        bus.vol_shift       = vol;
        bus.ear             = e;
        bus.mic             = m;
        bus.disable_ay      = dis_ay;
        bus.disable_turboay = dis_t;
    endtask

    task automatic mix_check(input string tag, input logic [31:0] exp_l, input logic [31:0] exp_r);
        pulse();
        pulse();
        check({tag, "_l"}, 32'(bus.pcm_l), exp_l);
        check({tag, "_r"}, 32'(bus.pcm_r), exp_r);
    endtask

    task automatic count_dac(input int n, output int ones_l, output int ones_r);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ones_l += int'(d_dac_l);
            ones_r += int'(d_dac_r);
        end
    endtask

    initial begin
        int ol, or_;
        logic prev_l, prev_r;

        bus.clk35en = 1'b0;
        dbus.ay1_abc = '0; dbus.ay2_abc = '0; dbus.stereo_mode = MODE_MONO;
        dbus.vol_shift = '0; dbus.ear = 1'b0; dbus.mic = 1'b0;
        dbus.disable_ay = 1'b0; dbus.disable_turboay = 1'b0;

        // Reset with active inputs and strobes: everything must stay at 0.
        set_in(24'hFFFFFF, 24'h000000, MODE_MONO, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        dbus.ear = 1'b1;
        repeat (4) pulse();
        @(negedge clk);
        check("rst_pcm_l", 32'(bus.pcm_l), 0);
        check("rst_pcm_r", 32'(bus.pcm_r), 0);
        check("rst_strobe", 32'(bus.pcm_strobe), 0);
        check("rst_dac_l", 32'(dac_l), 0);
        check("rst_dac_r", 32'(dac_r), 0);
        check("rst_d_dac_l", 32'(d_dac_l), 0);
        check("rst_d_pcm_l", 32'(dbus.pcm_l), 0);
        reset_n = 1'b1;
        dbus.ear = 1'b0;

        // First strobe after release still mixes the reset-cleared stage 1.
        pulse();
        check("rel1_strobe", 32'(bus.pcm_strobe), 1);
        check("rel1_pcm_l", 32'(bus.pcm_l), 0);
        check("rel1_pcm_r", 32'(bus.pcm_r), 0);
        @(negedge clk);
        check("rel1_strobe_off", 32'(bus.pcm_strobe), 0);
        pulse();
        check("rel2_pcm_l", 32'(bus.pcm_l), 865);
        check("rel2_pcm_r", 32'(bus.pcm_r), 865);

        // Stereo modes.
        set_in(24'hFF0000, 24'h000000, MODE_ABC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mix_check("abc_a255", 510, 0);
        set_in(24'hFF0000, 24'h000000, MODE_ABC, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        mix_check("abc_mic", 610, 100);
        set_in(24'h006400, 24'h000000, MODE_ACB, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mix_check("acb_b100", 0, 200);
        set_in(24'h0A1400, 24'h000005, MODE_ABC, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mix_check("abc_two_ay", 40, 30);
        set_in(24'h0A1400, 24'h000005, MODE_ABC, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        mix_check("dis_ay", 0, 0);

        // Split mode, then AY2 disabled: right side clears after two strobes.
        set_in(24'hFFFFFF, 24'h0A0A0A, MODE_SPLIT, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        mix_check("split", 1530, 60);
        bus.disable_turboay = 1'b1;
        pulse();
        check("split_dis1_r", 32'(bus.pcm_r), 60);
        pulse();
        check("split_dis2_r", 32'(bus.pcm_r), 0);
        check("split_dis2_l", 32'(bus.pcm_l), 1530);

        // Saturation and volume.
        set_in(24'hFFFFFF, 24'hFFFFFF, MODE_MONO, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mix_check("sat", 4095, 4095);
        bus.vol_shift = 2'd2;
        mix_check("sat_vol2", 1023, 1023);
        set_in(24'hFFFFFF, 24'h000000, MODE_MONO, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        mix_check("vol1", 432, 432);

        // No enable: outputs frozen despite input changes.
        bus.ay1_abc = 24'h000000;
        repeat (20) @(negedge clk);
        check("frozen_l", 32'(bus.pcm_l), 432);
        check("frozen_r", 32'(bus.pcm_r), 432);

        // Enable every 8 clks: strobe one clk wide, following each enable by one clk.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("strobe_pattern", 32'(bus.pcm_strobe), (i % 8 == 1) ? 1 : 0);
            bus.clk35en = (i % 8 == 0);
        end
        bus.clk35en = 1'b0;
        @(negedge clk);
        check("strobe_mix_l", 32'(bus.pcm_l), 50);

        // DAC at pcm=2048: alternates every clk.
        dbus.ear = 1'b1;
        pulse();
        pulse();
        check("dac_pcm_2048", 32'(dbus.pcm_l), 2048);
        repeat (4) @(negedge clk);
        prev_l = d_dac_l;
        prev_r = d_dac_r;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("dac_l_toggle", 32'(d_dac_l != prev_l), 1);
            check("dac_r_toggle", 32'(d_dac_r != prev_r), 1);
            prev_l = d_dac_l;
            prev_r = d_dac_r;
        end

        // pcm=1: exactly one 1 per 4096 clks.
        dbus.ear = 1'b0;
        dbus.mic = 1'b1;
        pulse();
        pulse();
        check("dac_pcm_1", 32'(dbus.pcm_l), 1);
        repeat (4) @(negedge clk);
        count_dac(4096, ol, or_);
        check("dac_l_ones_p1", 32'(ol), 1);
        check("dac_r_ones_p1", 32'(or_), 1);

        // pcm=0: pins stay low.
        dbus.mic = 1'b0;
        pulse();
        pulse();
        repeat (4) @(negedge clk);
        count_dac(200, ol, or_);
        check("dac_l_ones_p0", 32'(ol), 0);
        check("dac_r_ones_p0", 32'(or_), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
